itype_exec_ctrl: RTL and testbench

ITYPE_EXEC_CTRL -- requirements
Module: itype_exec_ctrl

---
 rtl/itype_pkg.sv | 43 ++++
 rtl/itype_exec_ctrl_if.sv | 33 +++
 rtl/itype_field_dec.sv | 65 ++++++
 rtl/itype_exec_ctrl.sv | 85 ++++++++
 tb/tb_itype_exec_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/itype_pkg.sv
// Shared types and constants for the OP-IMM execution controller.
// Opcode, funct3 codes, ALU encoding, FSM states, decode bundle.
package itype_pkg;

  localparam logic [6:0] OPC_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_XORI = 3'b100;
  localparam logic [2:0] F3_SRXI = 3'b101;
  localparam logic [2:0] F3_ORI  = 3'b110;
  localparam logic [2:0] F3_ANDI = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SLL = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SRL = 3'd3,
    ALU_SRA = 3'd4,
    ALU_OR  = 3'd5,
    ALU_AND = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } state_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rd;
    alu_op_e     op;
    logic [31:0] opb;
    logic        legal;
  } dec_t;

endpackage

// File: rtl/itype_exec_ctrl_if.sv
// Instruction handshake plus register-file and ALU ports.
// slave = controller view, master = environment view.
interface itype_exec_ctrl_if;

  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        rf_rd_en;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_rdata;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  modport slave (
    input  instr_valid, instr, rf_rdata, alu_y,
    output instr_ready, rf_rd_en, rf_rs1,
    output alu_op, alu_a, alu_b,
    output rf_wr_en, rf_rd, rf_wdata
  );

  modport master (
    output instr_valid, instr, rf_rdata, alu_y,
    input  instr_ready, rf_rd_en, rf_rs1,
    input  alu_op, alu_a, alu_b,
    input  rf_wr_en, rf_rd, rf_wdata
  );

endinterface

// File: rtl/itype_field_dec.sv
// Combinational OP-IMM decode: register fields, ALU op,
// operand-b value and legality.
module itype_field_dec
  import itype_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shift;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    dec.rs1   = instr[19:15];
    dec.rd    = instr[11:7];
    dec.op    = ALU_ADD;
    dec.legal = 1'b0;
    shift     = 1'b0;
    unique case (1'b1)
      (f3 == F3_ADDI): begin
        dec.op    = ALU_ADD;
        dec.legal = 1'b1;
      end
      (f3 == F3_SLLI): begin
        dec.op    = ALU_SLL;
        dec.legal = (f7 == F7_ZERO);
        shift     = 1'b1;
      end
      (f3 == F3_XORI): begin
        dec.op    = ALU_XOR;
        dec.legal = 1'b1;
      end
      (f3 == F3_SRXI): begin
        dec.op    = instr[30] ? ALU_SRA : ALU_SRL;
        dec.legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        shift     = 1'b1;
      end
      (f3 == F3_ORI): begin
        dec.op    = ALU_OR;
        dec.legal = 1'b1;
      end
      (f3 == F3_ANDI): begin
        dec.op    = ALU_AND;
        dec.legal = 1'b1;
      end
      default: begin
        dec.op    = ALU_ADD;
        dec.legal = 1'b0;
      end
    endcase
    if (opc != OPC_IMM)
      dec.legal = 1'b0;
    if (shift)
      dec.opb = {27'd0, instr[24:20]};
    else
      dec.opb = {{20{instr[31]}}, instr[31:20]};
  end

endmodule

// File: rtl/itype_exec_ctrl.sv
// Multi-cycle OP-IMM executor: read rs1, run ALU, write rd.
// Four cycles per legal instruction, two per rejected one.
module itype_exec_ctrl
  import itype_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  itype_exec_ctrl_if.slave   bus,
  output logic               illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q;
  state_e           state_d;
  dec_t             dec;
  logic [4:0]       rs1_q;
  logic [4:0]       rd_q;
  alu_op_e          op_q;
  logic [31:0]      opb_q;
  logic [31:0]      res_q;
  logic [CNT_W-1:0] ret_q;
  logic             accept;

  itype_field_dec u_dec (
    .instr (bus.instr),
    .dec   (dec)
  );

  assign accept = bus.instr_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)
                state_d = dec.legal ? S_READ : S_ERR;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rs1_q   <= '0;
      rd_q    <= '0;
      op_q    <= ALU_ADD;
      opb_q   <= '0;
      res_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q <= dec.rs1;
        rd_q  <= dec.rd;
        op_q  <= dec.op;
        opb_q <= dec.opb;
      end
      if (state_q == S_EXEC)
        res_q <= bus.alu_y;
      // x0 writes are suppressed but still count as retired
      if (state_q == S_WB)
        ret_q <= ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.rf_rd_en    = (state_q == S_READ);
  assign bus.rf_rs1      = rs1_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_a       = (state_q == S_EXEC) ? bus.rf_rdata : '0;
  assign bus.alu_b       = (state_q == S_EXEC) ? opb_q : '0;
  assign bus.rf_wr_en    = (state_q == S_WB) && (rd_q != 5'd0);
  assign bus.rf_rd       = rd_q;
  assign bus.rf_wdata    = res_q;
  assign illegal         = (state_q == S_ERR);
  assign busy            = (state_q != S_IDLE);
  assign retired         = ret_q;

endmodule

// File: tb/tb_itype_exec_ctrl.sv
// Scoreboard bench for itype_exec_ctrl: directed vectors,
// held-valid throughput, counter wrap and random OP-IMM mix.
module tb_itype_exec_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          illegal;
  logic          busy;
  logic [CW-1:0] retired;
  logic [31:0]   rf [32];

  itype_exec_ctrl_if bus ();

  itype_exec_ctrl #(.CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .illegal (illegal),
    .busy    (busy),
    .retired (retired)
  );

  typedef struct {
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    bus.rf_rdata <= bus.rf_rd_en ? rf[bus.rf_rs1] : $urandom;

  always_comb begin
    bus.alu_y = 32'd0;
    case (bus.alu_op)
      3'd0: bus.alu_y = bus.alu_a + bus.alu_b;
      3'd1: bus.alu_y = bus.alu_a << bus.alu_b[4:0];
      3'd2: bus.alu_y = bus.alu_a ^ bus.alu_b;
      3'd3: bus.alu_y = bus.alu_a >> bus.alu_b[4:0];
      3'd4: bus.alu_y = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      3'd5: bus.alu_y = bus.alu_a | bus.alu_b;
      3'd6: bus.alu_y = bus.alu_a & bus.alu_b;
      default: bus.alu_y = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Reference: architectural OP-IMM semantics on the bench regfile
  function automatic exp_t model(input logic [31:0] i);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] imm;
    int          sh;
    f3  = i[14:12];
    f7  = i[31:25];
    a   = rf[i[19:15]];
    imm = {{20{i[31]}}, i[31:20]};
    sh  = int'(i[24:20]);
    e.rd    = i[11:7];
    e.wdata = 32'd0;
    e.ill   = 1'b0;
    if (i[6:0] != 7'h13) e.ill = 1'b1;
    else case (f3)
      3'd0: e.wdata = a + imm;
      3'd1: if (f7 == 7'h00) e.wdata = a << sh;
            else e.ill = 1'b1;
      3'd4: e.wdata = a ^ imm;
      3'd5: if (f7 == 7'h00) e.wdata = a >> sh;
            else if (f7 == 7'h20)
              e.wdata = 32'($signed(a) >>> sh);
            else e.ill = 1'b1;
      3'd6: e.wdata = a | imm;
      3'd7: e.wdata = a & imm;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr(input bit legal);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    int          r;
    r   = $urandom_range(0, 3);
    f7  = (r == 1) ? 7'h20 : (r == 2) ? 7'($urandom) : 7'h00;
    f3  = 3'($urandom);
    opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h13;
    if (legal) begin
      opc = 7'h13;
      if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
      if (f3 == 3'd1) f7 = 7'h00;
      if (f3 == 3'd5 && f7 != 7'h20) f7 = 7'h00;
    end
    return {f7, 5'($urandom), 5'($urandom), f3,
            5'($urandom), opc};
  endfunction

  task automatic issue(input logic [31:0] i);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) chk("issue_timeout", 0, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = i;
    q.push_back(model(i));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops on each illegal pulse or retired step
  initial begin : monitor
    logic [CW-1:0] prev;
    logic          pv;
    logic [4:0]    prd;
    logic [31:0]   pd;
    exp_t          e;
    prev = '0;
    pv   = 1'b0;
    prd  = '0;
    pd   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev = retired;
        pv   = 1'b0;
      end else begin
        chk("strobe_excl",
            32'(bus.rf_rd_en) + 32'(bus.rf_wr_en) + 32'(illegal) > 1,
            0);
        if (retired != prev) begin
          chk("ret_step", 32'(retired), 32'(CW'(prev + 1'b1)));
          if (q.size() == 0) chk("sb_empty_ret", 0, 1);
          else begin
            e = q.pop_front();
            chk("ret_legal", 32'(e.ill), 0);
            if (e.rd != 0) begin
              chk("wr_seen", 32'(pv), 1);
              chk("wr_rd", 32'(prd), 32'(e.rd));
              chk("wr_data", pd, e.wdata);
            end else
              chk("x0_nowr", 32'(pv), 0);
          end
          pv   = 1'b0;
          prev = retired;
        end
        if (illegal) begin
          if (q.size() == 0) chk("sb_empty_ill", 0, 1);
          else begin
            e = q.pop_front();
            chk("ill_expect", 32'(e.ill), 1);
          end
        end
        if (bus.rf_wr_en) begin
          pv  = 1'b1;
          prd = bus.rf_rd;
          pd  = bus.rf_wdata;
        end
      end
    end
  end

  initial begin : stim
    logic [CW-1:0] r0;
    logic [31:0]   lst [3];
    int            acc [3];
    int            n;
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    rf[0] = 32'd0;
    rf[7] = 32'h10;
    rf[5] = 32'h8000_0000;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy", 32'(bus.instr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ret", 32'(retired), 0);
    chk("rst_rs1", 32'(bus.rf_rs1), 0);
    chk("rst_aluop", 32'(bus.alu_op), 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    issue(enc(12'h300, 5'd7, 3'd0, 5'd9));
    chk("addi_rden", 32'(bus.rf_rd_en), 1);
    chk("addi_rs1", 32'(bus.rf_rs1), 7);
    @(negedge clk);
    @(negedge clk);
    chk("addi_wren", 32'(bus.rf_wr_en), 1);
    chk("addi_rd", 32'(bus.rf_rd), 9);
    chk("addi_wdata", bus.rf_wdata, 32'h310);
    wait_idle();
    chk("addi_ret", 32'(retired), 1);

    issue(enc(12'd5, 5'd5, 3'd0, 5'd0));
    wait_idle();
    chk("x0_ret", 32'(retired), 2);

    issue(enc({7'h20, 5'd4}, 5'd5, 3'd5, 5'd13));
    @(negedge clk);
    chk("srai_op", 32'(bus.alu_op), 4);
    chk("srai_b", bus.alu_b, 4);
    @(negedge clk);
    chk("srai_wdata", bus.rf_wdata, 32'hF800_0000);
    wait_idle();

    r0 = retired;
    issue(32'h1234_5678);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_rden", 32'(bus.rf_rd_en), 0);
    @(negedge clk);
    chk("ill_once", 32'(illegal), 0);
    issue(enc({7'h22, 5'd3}, 5'd1, 3'd1, 5'd2));
    chk("slli_bad", 32'(illegal), 1);
    wait_idle();
    chk("ill_ret", 32'(retired), 32'(r0));

    issue(enc(12'h7, 5'd7, 3'd0, 5'd4));
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    #1;
    chk("rx_busy", 32'(busy), 0);
    chk("rx_wren", 32'(bus.rf_wr_en), 0);
    chk("rx_alua", bus.alu_a, 0);
    chk("rx_ret", 32'(retired), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_rdy", 32'(bus.instr_ready), 1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(bus.rf_wr_en);
    end
    chk("rx_nowr", n, 0);

    for (int k = 0; k < 17; k++) issue(rand_instr(1'b1));
    wait_idle();
    chk("wrap17", 32'(retired), 1);

    for (int k = 0; k < 3; k++) lst[k] = rand_instr(1'b1);
    n = 0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = lst[0];
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (bus.instr_ready) begin
        q.push_back(model(lst[n]));
        acc[n] = c;
        n++;
      end
      @(negedge clk);
      bus.instr = (n < 3) ? lst[n] : $urandom;
    end
    bus.instr_valid = 1'b0;
    chk("tp_count", n, 3);
    if (n == 3) begin
      chk("tp_gap01", acc[1] - acc[0], 4);
      chk("tp_gap12", acc[2] - acc[1], 4);
    end
    wait_idle();

    for (int k = 0; k < 60; k++) issue(rand_instr(1'b0));
    wait_idle();
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
